// File: rtl/decrypt_code.sv
// Receive-side descrambler and framer: regenerates the 4-bit LFSR keystream,
// recovers plaintext, hunts for the sync byte and deserialises framed payload.
module decrypt_code #(
  parameter logic [7:0] SYNC_WORD   = 8'hA5,
  parameter int         FRAME_BYTES = 4,
  parameter int         MISS_MAX    = 2,
  parameter logic [3:0] LFSR_SEED   = 4'b0001
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_code,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_sof,
  output logic       o_locked,
  output logic       o_sync_err
);

  localparam logic [0:0] ST_HUNT   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  localparam logic [7:0] FRAME_LAST = FRAME_BYTES[7:0];
  localparam logic [3:0] MISS_LIM   = MISS_MAX[3:0];

  logic [3:0] ks_q, ks_d;
  logic [7:0] sh_q, sh_d;
  logic [0:0] state_q, state_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] byte_q, byte_d;
  logic [3:0] miss_q, miss_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       sof_q, sof_d;
  logic       err_q, err_d;

  logic       plain_bit;
  logic [7:0] window;
  logic [7:0] byte_next;
  logic [3:0] miss_inc;

  always_comb begin
    plain_bit = i_code ^ ks_q[0];
    window    = {sh_q[6:0], plain_bit};
    byte_next = (byte_q == FRAME_LAST) ? 8'd0 : byte_q + 8'd1;
    miss_inc  = miss_q + 4'd1;

    ks_d    = {ks_q[3] ^ ks_q[0], ks_q[3:1]};
    sh_d    = window;
    state_d = state_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    miss_d  = miss_q;
    data_d  = data_q;
    valid_d = 1'b0;
    sof_d   = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      ST_HUNT: begin
        if (window == SYNC_WORD) begin
          state_d = ST_LOCKED;
          bit_d   = 3'd0;
          byte_d  = 8'd0;
          miss_d  = 4'd0;
        end
      end
      default: begin
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) begin
          byte_d = byte_next;
          if (byte_next != 8'd0) begin
            valid_d = 1'b1;
            data_d  = window;
            sof_d   = (byte_next == 8'd1);
          end else if (window == SYNC_WORD) begin
            miss_d = 4'd0;
          end else begin
            // Bad header: flywheel until the miss limit, then fall back to hunting.
            err_d  = 1'b1;
            miss_d = miss_inc;
            if (miss_inc >= MISS_LIM) begin
              state_d = ST_HUNT;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ks_q    <= LFSR_SEED;
      sh_q    <= 8'h00;
      state_q <= ST_HUNT;
      bit_q   <= 3'd0;
      byte_q  <= 8'd0;
      miss_q  <= 4'd0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ks_q    <= ks_d;
      sh_q    <= sh_d;
      state_q <= state_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      miss_q  <= miss_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sof_q   <= sof_d;
      err_q   <= err_d;
    end
  end

  assign o_data     = data_q;
  assign o_valid    = valid_q;
  assign o_sof      = sof_q;
  assign o_sync_err = err_q;
  assign o_locked   = (state_q == ST_LOCKED);

endmodule

// File: doc/decrypt_code.md
# decrypt_code

Receive-side descrambler and framer that sits directly downstream of the 4-bit LFSR scrambler stage. It consumes the scrambled serial bit stream (one bit per clock), regenerates the identical keystream, and recovers the plaintext. It then hunts for a plaintext sync byte, deserialises each frame into bytes and flags sync errors. On loss of frame alignment it falls back to hunting.

## Interface
Parameters:
- SYNC_WORD, 8'hA5: plaintext frame header byte.
- FRAME_BYTES, 4: payload bytes per frame that follow each header. Legal range 1..255.
- MISS_MAX, 2: consecutive bad headers that drop lock. Legal range 1..15.
- LFSR_SEED, 4'b0001: keystream register value on reset. Must match the scrambler.

Ports:
- i_clk, in, 1: rising-edge clock, shared with the scrambler.
- i_reset, in, 1: asynchronous, active-high reset. Driven from the same reset source as the scrambler, inverted.
- i_code, in, 1: scrambled bit, one new bit per clock, MSB of each byte first.
- o_data, out, 8: recovered payload byte, registered.
- o_valid, out, 1: one-cycle strobe, o_data valid.
- o_sof, out, 1: high together with o_valid on the first payload byte of a frame.
- o_locked, out, 1: frame alignment held.
- o_sync_err, out, 1: one-cycle strobe when a header slot mismatches while locked.

## Operation
- Keystream register ks[3:0]:
  - reset = LFSR_SEED.
  - every edge: ks[2:0] <= ks[3:1]; ks[3] <= ks[3]^ks[0].
  - keystream bit = ks[0]. Free-running, never stalls; period 15.
  - From seed 0001 the keystream bits are 1,0,0,0,1,1,1,1,0,1,0,1,1,0,0, then repeat.
- Plaintext bit p = i_code ^ ks[0] (combinational). It is shifted into an 8-bit history register sh on every edge: sh <= {sh[6:0], p}.
- FSM states HUNT, LOCKED. Reset → HUNT.
  - HUNT: when {sh[6:0],p} == SYNC_WORD at an edge, go to LOCKED and clear the bit counter (0..7), byte counter (0..FRAME_BYTES) and miss counter. Any bit offset is accepted.
  - LOCKED, byte counter 1..FRAME_BYTES (payload): each 8th bit emits byte {sh[6:0],p}. o_sof is set when the byte counter = 1.
  - LOCKED, header slot (byte counter wraps to 0): compare the 8 bits with SYNC_WORD.
    - Match: clear the miss counter.
    - Mismatch: pulse o_sync_err and increment the miss counter.
    - If the miss counter reaches MISS_MAX: go to HUNT, deassert o_locked, emit no byte.
    - Otherwise stay LOCKED (flywheel) and deliver the next frame's payload normally.
  - While LOCKED, SYNC_WORD patterns inside the payload are ignored.
  - Header bytes are never output.
- Re-hunt after lock loss starts from the edge following the failing header slot. The history register is not cleared.

## Timing
- Reset values: o_data=8'h00, o_valid=0, o_sof=0, o_locked=0, o_sync_err=0, ks=LFSR_SEED, sh=8'h00, state HUNT.
- Reset mid-frame: all of the above take effect immediately (asynchronous). No partial byte is emitted.
- The first bit sampled after reset release is XORed with keystream bit 1.
- Latency: o_valid, o_sof and o_data are registered. They are high in the cycle following the edge that samples the byte's 8th bit.
- o_locked rises in the cycle after the edge sampling the last header bit. It falls in the cycle after the edge sampling the MISS_MAX-th bad header.
- o_sync_err is high in the cycle after the edge sampling the bad header's 8th bit. It is simultaneous with the o_locked fall when lock is lost.
- Byte spacing is exactly 8 clocks. o_valid is never high on two consecutive cycles.
- Frame spacing is (FRAME_BYTES+1)*8 clocks.

## Test plan
- Aligned start, default parameters:
  - Stimulus: plaintext A5,11,22,33,44 scrambled with the seed keystream (first i_code byte = 8'h2A).
  - Required: o_locked after 8 clocks; o_valid bytes 11(o_sof=1),22,33,44; no o_sync_err.
- Offset hunt: 3 random plaintext bits precede A5, then a 4-byte payload. Required: lock after bit 11 and correct payload bytes.
- Flywheel: the second frame header is corrupted to 5A. Required: one o_sync_err pulse, o_locked stays 1, and the third frame's payload is delivered.
- Lock loss: two consecutive bad headers. Required: the second o_sync_err coincides with the o_locked fall; no o_valid until the next A5.
- False sync: payload contains A5 while LOCKED. Required: A5 is output as data and alignment is unchanged.
- Reset mid-byte: i_reset is asserted 3 bits into a payload byte. Required: all outputs go to 0 immediately, and the stream relocks after re-synchronised traffic.
